// File: rtl/ddr_pkg.sv
// rtl/ddr_pkg.sv - shared controller request types
//
// Purpose: request encoding used on the controller command-entry port.
// Ports:   none (package).
package ddr_pkg;

  // Auto-precharge variants first so the idle/reset encoding is all zeros.
  typedef enum logic [1:0] {
    WRA_R = 2'd0,
    RDA_R = 2'd1,
    WR_R  = 2'd2,
    RD_R  = 2'd3
  } request_t;

endpackage

// File: rtl/ddr_tg_pkg.sv
// rtl/ddr_tg_pkg.sv - types and constants for the DDR traffic generator
//
// Purpose: FSM state, address-mode and request-mix enums, LFSR taps and a
//          write-classification helper shared by the traffic generator.
// Ports:   none (package).
package ddr_tg_pkg;
  import ddr_pkg::*;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_BUSY = 2'd1,
    S_ISSUE     = 2'd2,
    S_GAP       = 2'd3
  } tg_state_t;

  typedef enum logic [1:0] {
    MODE_FIXED = 2'd0,
    MODE_SEQ   = 2'd1,
    MODE_LFSR  = 2'd2,
    MODE_RSVD  = 2'd3
  } tg_mode_t;

  typedef enum logic [1:0] {
    MIX_WRA    = 2'd0,
    MIX_RDA    = 2'd1,
    MIX_ALT_AP = 2'd2,
    MIX_ALT    = 2'd3
  } tg_mix_t;

  // Galois (right-shift) feedback mask: x^32 + x^22 + x^2 + x + 1.
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  function automatic logic is_write(input request_t r);
    return (r == WRA_R) || (r == WR_R);
  endfunction

endpackage

// File: rtl/ddr_tg_lfsr.sv
// rtl/ddr_tg_lfsr.sv - 32-bit Galois LFSR address source
//
// Purpose: pseudo-random address generator, steps once per advance pulse.
// Ports:
//   clk     in  : clock, posedge
//   rst_n   in  : asynchronous active-low reset, loads SEED
//   advance in  : step the register by one position this cycle
//   value   out : current LFSR contents
module ddr_tg_lfsr
  import ddr_tg_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hACE1_0001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        advance,
  output logic [31:0] value
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= SEED;
    end else if (advance) begin
      value <= (value >> 1) ^ (value[0] ? LFSR_TAPS : 32'h0);
    end
  end

endmodule

// File: rtl/ddr_traffic_gen.sv
// rtl/ddr_traffic_gen.sv - programmable read/write request generator
//
// Purpose: issues NUM_REQ requests into the controller command-entry port
//          with a fixed, sequential or LFSR address pattern, a selectable
//          read/write mix and at least GAP idle cycles between requests,
//          waiting while the controller reports busy.
// Build option: DDR_TG_LFSR_EN enables the LFSR address mode; without it
//          mode 2 behaves as sequential and no LFSR is built.
// Ports:
//   CK_t      in  : clock, posedge
//   reset_n   in  : asynchronous active-low reset
//   start     in  : begin a run (accepted only when idle)
//   mode      in  : 0 fixed, 1 sequential, 2 LFSR, 3 fixed
//   mix       in  : 0 WRA, 1 RDA, 2 WRA/RDA pairs, 3 WR/RD pairs
//   base_addr in  : first address
//   stride    in  : sequential increment
//   busy      in  : controller cannot accept a command
//   cmd_rdy   out : one-cycle command-valid pulse
//   log_addr  out : request address, held until the next issue
//   request   out : request type, held until the next issue
//   active    out : run in progress (through the done cycle)
//   done      out : one-cycle pulse after the final gap
//   wr_cnt    out : writes issued this run, saturating
//   rd_cnt    out : reads issued this run, saturating
module ddr_traffic_gen
  import ddr_pkg::*;
  import ddr_tg_pkg::*;
#(
  parameter int          ADDR_W    = 40,
  parameter int          NUM_REQ   = 16,
  parameter int          GAP       = 8,
  parameter int          CNT_W     = 16,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_0001
) (
  input  logic              CK_t,
  input  logic              reset_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [1:0]        mix,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] stride,
  input  logic              busy,
  output logic              cmd_rdy,
  output logic [ADDR_W-1:0] log_addr,
  output request_t          request,
  output logic              active,
  output logic              done,
  output logic [CNT_W-1:0]  wr_cnt,
  output logic [CNT_W-1:0]  rd_cnt
);

  localparam int ISS_W = $clog2(NUM_REQ + 1);
  localparam int GAP_W = (GAP < 2) ? 1 : $clog2(GAP);
  localparam logic [ISS_W-1:0] LAST_IDX  = ISS_W'(NUM_REQ - 1);
  localparam logic [ISS_W-1:0] ALL_REQ   = ISS_W'(NUM_REQ);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'((GAP > 0) ? GAP - 1 : 0);

  if (NUM_REQ < 1) begin : g_chk_num
    $error("ddr_traffic_gen: NUM_REQ must be at least 1");
  end
  if (LFSR_SEED == 32'h0) begin : g_chk_seed
    $error("ddr_traffic_gen: LFSR_SEED must be nonzero");
  end

  tg_state_t         state_q, state_d;
  tg_mode_t          mode_q, mode_in;
  tg_mix_t           mix_q;
  logic [ADDR_W-1:0] stride_q;
  logic [ADDR_W-1:0] addr_ptr_q;
  logic              phase_q;     // 0: write half of a pair, 1: read half
  logic [ISS_W-1:0]  issued_q;
  logic [GAP_W-1:0]  gap_q;
  logic              done_q, done_d;
  logic              launch;
  logic              advance;     // address moves on after this request
  logic [ADDR_W-1:0] next_addr;
  request_t          next_req;

  // A start arriving in the done cycle is still inside the run and is dropped.
  assign launch = (state_q == S_IDLE) && start && !done_q;

  // Pair mixes share one address across write+read, so advance after the read.
  assign advance = (mix_q == MIX_WRA) || (mix_q == MIX_RDA) || phase_q;

  always_comb begin
    mode_in = tg_mode_t'(mode);
    if (mode_in == MODE_RSVD) mode_in = MODE_FIXED;
`ifndef DDR_TG_LFSR_EN
    if (mode_in == MODE_LFSR) mode_in = MODE_SEQ;
`endif
  end

`ifdef DDR_TG_LFSR_EN
  logic [31:0] lfsr_val;
  logic        lfsr_adv;

  assign lfsr_adv = (state_q == S_ISSUE) && advance && (mode_q == MODE_LFSR);

  ddr_tg_lfsr #(
    .SEED    (LFSR_SEED)
  ) u_lfsr (
    .clk     (CK_t),
    .rst_n   (reset_n),
    .advance (lfsr_adv),
    .value   (lfsr_val)
  );
`endif

  always_comb begin
    next_addr = addr_ptr_q;
`ifdef DDR_TG_LFSR_EN
    if (mode_q == MODE_LFSR) next_addr = ADDR_W'(lfsr_val);
`endif
  end

  always_comb begin
    next_req = WRA_R;
    case (mix_q)
      MIX_WRA:    next_req = WRA_R;
      MIX_RDA:    next_req = RDA_R;
      MIX_ALT_AP: next_req = phase_q ? RDA_R : WRA_R;
      default:    next_req = phase_q ? RD_R : WR_R;
    endcase
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    cmd_rdy = (state_q == S_ISSUE);
    active  = (state_q != S_IDLE) || done_q;
    case (state_q)
      S_IDLE: begin
        if (launch) state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (!busy) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (GAP > 0) begin
          state_d = S_GAP;
        end else if (issued_q == LAST_IDX) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = S_WAIT_BUSY;
        end
      end
      default: begin
        if (gap_q == GAP_LAST) begin
          if (issued_q == ALL_REQ) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_WAIT_BUSY;
          end
        end
      end
    endcase
  end

  assign done = done_q;

  always_ff @(posedge CK_t or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      mode_q     <= MODE_FIXED;
      mix_q      <= MIX_WRA;
      stride_q   <= '0;
      addr_ptr_q <= '0;
      phase_q    <= 1'b0;
      issued_q   <= '0;
      gap_q      <= '0;
      done_q     <= 1'b0;
      log_addr   <= '0;
      request    <= WRA_R;
      wr_cnt     <= '0;
      rd_cnt     <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      case (state_q)
        S_IDLE: begin
          if (launch) begin
            mode_q     <= mode_in;
            mix_q      <= tg_mix_t'(mix);
            stride_q   <= stride;
            addr_ptr_q <= base_addr;
            phase_q    <= 1'b0;
            issued_q   <= '0;
            wr_cnt     <= '0;
            rd_cnt     <= '0;
          end
        end
        S_WAIT_BUSY: begin
          // Load the outputs on the way into ISSUE so they are valid with cmd_rdy.
          if (!busy) begin
            log_addr <= next_addr;
            request  <= next_req;
          end
        end
        S_ISSUE: begin
          issued_q <= issued_q + ISS_W'(1);
          gap_q    <= '0;
          if (is_write(request)) begin
            if (wr_cnt != '1) wr_cnt <= wr_cnt + CNT_W'(1);
          end else begin
            if (rd_cnt != '1) rd_cnt <= rd_cnt + CNT_W'(1);
          end
          if ((mix_q == MIX_ALT_AP) || (mix_q == MIX_ALT)) phase_q <= !phase_q;
          if (advance && (mode_q == MODE_SEQ)) addr_ptr_q <= addr_ptr_q + stride_q;
        end
        default: begin
          gap_q <= gap_q + GAP_W'(1);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_traffic_gen.sv
// tb/tb_ddr_traffic_gen.sv - self-checking bench for ddr_traffic_gen
module tb_ddr_traffic_gen;
  import ddr_pkg::*;

  localparam logic [31:0] SEED = 32'hACE1_0001;
  localparam logic [31:0] TAPS = 32'h8020_0003;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, start, busy, sel;
  logic [1:0]  mode, mix;
  logic [39:0] base_addr, stride;
  logic        start_a, start_b;
  assign start_a = start & ~sel;
  assign start_b = start & sel;

  logic        cmd_rdy_a, active_a, done_a;
  logic [39:0] log_addr_a;
  request_t    request_a;
  logic [15:0] wr_cnt_a, rd_cnt_a;

  logic        cmd_rdy_b, active_b, done_b;
  logic [7:0]  log_addr_b;
  request_t    request_b;
  logic [1:0]  wr_cnt_b, rd_cnt_b;

  ddr_traffic_gen #(
    .ADDR_W(40), .NUM_REQ(4), .GAP(8), .CNT_W(16), .LFSR_SEED(SEED)
  ) u_dut_a (
    .CK_t(clk), .reset_n(reset_n), .start(start_a), .mode(mode), .mix(mix),
    .base_addr(base_addr), .stride(stride), .busy(busy),
    .cmd_rdy(cmd_rdy_a), .log_addr(log_addr_a), .request(request_a),
    .active(active_a), .done(done_a), .wr_cnt(wr_cnt_a), .rd_cnt(rd_cnt_a)
  );

  ddr_traffic_gen #(
    .ADDR_W(8), .NUM_REQ(5), .GAP(0), .CNT_W(2), .LFSR_SEED(SEED)
  ) u_dut_b (
    .CK_t(clk), .reset_n(reset_n), .start(start_b), .mode(mode), .mix(mix),
    .base_addr(base_addr[7:0]), .stride(stride[7:0]), .busy(busy),
    .cmd_rdy(cmd_rdy_b), .log_addr(log_addr_b), .request(request_b),
    .active(active_b), .done(done_b), .wr_cnt(wr_cnt_b), .rd_cnt(rd_cnt_b)
  );

  logic        s_cmd, s_act, s_done;
  logic [63:0] s_addr;
  request_t    s_req;
  logic [31:0] s_wr, s_rd;

  always_comb begin
    if (sel) begin
      s_cmd = cmd_rdy_b; s_act = active_b; s_done = done_b; s_req = request_b;
      s_addr = {56'h0, log_addr_b}; s_wr = {30'h0, wr_cnt_b}; s_rd = {30'h0, rd_cnt_b};
    end else begin
      s_cmd = cmd_rdy_a; s_act = active_a; s_done = done_a; s_req = request_a;
      s_addr = {24'h0, log_addr_a}; s_wr = {16'h0, wr_cnt_a}; s_rd = {16'h0, rd_cnt_a};
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: expected address/request list for one run.
  logic [63:0] exp_addr[$];
  request_t    exp_req[$];
  int          exp_wr, exp_rd;
  logic [31:0] tb_lfsr[2];

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? TAPS : 32'h0);
  endfunction

  task automatic build_model(input logic s, input int md, input int mx,
                             input logic [63:0] b, input logic [63:0] st);
    int w, nreq, eff, k, pk, wr, rd, adv, cmax;
    logic [63:0] mask, a;
    logic [31:0] l;
    request_t r;
    w    = s ? 8 : 40;
    nreq = s ? 5 : 4;
    cmax = s ? 3 : 65535;
    mask = (64'd1 << w) - 64'd1;
    eff  = (md == 3) ? 0 : md;
`ifndef DDR_TG_LFSR_EN
    if (eff == 2) eff = 1;
`endif
    exp_addr.delete();
    exp_req.delete();
    wr = 0; rd = 0; pk = 0;
    l = tb_lfsr[s];
    for (int i = 0; i < nreq; i++) begin
      k = (mx >= 2) ? i / 2 : i;
      if (k != pk) begin l = lfsr_step(l); pk = k; end
      case (eff)
        0:       a = b & mask;
        1:       a = (b + 64'(k) * st) & mask;
        default: a = {32'h0, l} & mask;
      endcase
      case (mx)
        0:       r = WRA_R;
        1:       r = RDA_R;
        2:       r = (i % 2 == 1) ? RDA_R : WRA_R;
        default: r = (i % 2 == 1) ? RD_R : WR_R;
      endcase
      if (r == WRA_R || r == WR_R) wr++; else rd++;
      exp_addr.push_back(a);
      exp_req.push_back(r);
    end
    adv = (mx >= 2) ? nreq / 2 : nreq;
    if (eff == 2) repeat (adv) tb_lfsr[s] = lfsr_step(tb_lfsr[s]);
    exp_wr = (wr > cmax) ? cmax : wr;
    exp_rd = (rd > cmax) ? cmax : rd;
  endtask

  function automatic logic pick_busy(input int bm, input int bk, input int c);
    if (bm == 1) return c < bk;
    if (bm == 2) return $urandom_range(0, 2) == 0;
    return 1'b0;
  endfunction

  logic [63:0] obs_first, obs_last;
  int          obs_first_cyc, obs_wr, obs_rd;

  // One full run on the selected DUT, checked cycle by cycle against the rules:
  // a pulse lands on the first cycle >= earliest whose previous cycle had busy low.
  task automatic run_case(input logic s, input int md, input int mx,
                          input logic [63:0] b, input logic [63:0] st,
                          input int bm, input int bk);
    int n, last, cyc, nreq, gap, earliest;
    bit fin, exp_cmd, exp_done;
    bit bh[$];
    sel = s;
    build_model(s, md, mx, b, st);
    nreq = s ? 5 : 4;
    gap  = s ? 0 : 8;
    obs_first = '0; obs_last = '0; obs_first_cyc = -1; obs_wr = -1; obs_rd = -1;
    @(posedge clk); #1;
    start = 1'b1; mode = 2'(md); mix = 2'(mx);
    base_addr = b[39:0]; stride = st[39:0];
    busy = pick_busy(bm, bk, 0);
    bh.delete();
    bh.push_back(busy);
    n = 0; last = -100; cyc = 0; fin = 0;
    while (!fin && cyc < 600) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) begin
        start = 1'b0;
        mode = 2'($urandom); mix = 2'($urandom);
        base_addr = 40'({$urandom, $urandom}); stride = 40'({$urandom, $urandom});
        check("cnt_clear_wr", s_wr, 0);
        check("cnt_clear_rd", s_rd, 0);
      end
      if (cyc == 5) start = 1'b1;
      if (cyc == 6) start = 1'b0;
      earliest = (n == 0) ? 2 : last + gap + 2;
      exp_cmd = (n < nreq) && (cyc >= earliest) && !bh[cyc-1];
      check("cmd_rdy", s_cmd, exp_cmd);
      if (exp_cmd) begin
        check("log_addr", s_addr, exp_addr[n]);
        check("request", s_req, exp_req[n]);
        if (n == 0) begin obs_first = s_addr; obs_first_cyc = cyc; end
        obs_last = s_addr;
        n++;
        last = cyc;
      end else if (n > 0) begin
        check("addr_hold", s_addr, exp_addr[n-1]);
      end
      exp_done = (n == nreq) && (cyc == last + gap + 1);
      check("done", s_done, exp_done);
      check("active", s_act, 1);
      if (exp_done) begin
        fin = 1;
        obs_wr = int'(s_wr); obs_rd = int'(s_rd);
        check("wr_cnt", s_wr, exp_wr);
        check("rd_cnt", s_rd, exp_rd);
      end
      busy = pick_busy(bm, bk, cyc);
      bh.push_back(busy);
    end
    check("run_completed", fin, 1);
    busy = 1'b0;
    @(posedge clk); #1;
    check("active_after", s_act, 0);
    check("done_after", s_done, 0);
  endtask

  typedef struct {
    logic        s;
    int          md, mx;
    logic [63:0] b, st;
    int          bm, bk;
    logic [63:0] first_addr, last_addr;
    bit          chk_last;
    int          first_cyc, wr, rd;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int cnt, cyc;
    // Entry 0 runs first after reset, so an LFSR build sees the seed.
`ifdef DDR_TG_LFSR_EN
    tbl[0] = '{1'b0, 2, 0, 64'h200, 64'h8, 0, 0, 64'hACE1_0001, 64'h0, 1'b0, 2, 4, 0};
`else
    tbl[0] = '{1'b0, 2, 0, 64'h200, 64'h8, 0, 0, 64'h200, 64'h218, 1'b1, 2, 4, 0};
`endif
    tbl[1] = '{1'b0, 1, 0, 64'h100, 64'h40, 0, 0, 64'h100, 64'h1C0, 1'b1, 2, 4, 0};
    tbl[2] = '{1'b0, 1, 2, 64'h1000, 64'h10, 0, 0, 64'h1000, 64'h1010, 1'b1, 2, 2, 2};
    tbl[3] = '{1'b0, 0, 1, 64'h55, 64'h7, 1, 20, 64'h55, 64'h55, 1'b1, 21, 0, 4};
    tbl[4] = '{1'b0, 3, 3, 64'hAB_CDEF_0123, 64'h1, 0, 0, 64'hAB_CDEF_0123, 64'hAB_CDEF_0123, 1'b1, 2, 2, 2};
    tbl[5] = '{1'b1, 1, 0, 64'hF0, 64'h20, 0, 0, 64'hF0, 64'h70, 1'b1, 2, 3, 0};
    tbl[6] = '{1'b1, 1, 3, 64'hFF, 64'h1, 0, 0, 64'hFF, 64'h01, 1'b1, 2, 3, 2};

    reset_n = 1'b0; start = 1'b0; busy = 1'b0; sel = 1'b0;
    mode = 2'd0; mix = 2'd0; base_addr = '0; stride = '0;
    tb_lfsr[0] = SEED; tb_lfsr[1] = SEED;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_rdy", cmd_rdy_a, 0);
    check("rst_log_addr", log_addr_a, 0);
    check("rst_request", request_a, WRA_R);
    check("rst_active", active_a, 0);
    check("rst_done", done_a, 0);
    check("rst_wr_cnt", wr_cnt_a, 0);
    check("rst_rd_cnt", rd_cnt_a, 0);
    check("rst_b_addr", log_addr_b, 0);
    reset_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_case(tbl[i].s, tbl[i].md, tbl[i].mx, tbl[i].b, tbl[i].st, tbl[i].bm, tbl[i].bk);
      check($sformatf("tbl%0d_first_addr", i), obs_first, tbl[i].first_addr);
      if (tbl[i].chk_last) check($sformatf("tbl%0d_last_addr", i), obs_last, tbl[i].last_addr);
      check($sformatf("tbl%0d_first_cyc", i), obs_first_cyc, tbl[i].first_cyc);
      check($sformatf("tbl%0d_wr", i), obs_wr, tbl[i].wr);
      check($sformatf("tbl%0d_rd", i), obs_rd, tbl[i].rd);
    end

    // Reset after the second request: outputs clear at once and no done follows.
    sel = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; mode = 2'd1; mix = 2'd0; base_addr = 40'h300; stride = 40'h10; busy = 1'b0;
    cnt = 0; cyc = 0;
    while (cnt < 2 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
      if (cmd_rdy_a) cnt++;
    end
    check("rst_mid_reached", cnt, 2);
    reset_n = 1'b0;
    #1;
    check("rst_mid_cmd_rdy", cmd_rdy_a, 0);
    check("rst_mid_log_addr", log_addr_a, 0);
    check("rst_mid_request", request_a, WRA_R);
    check("rst_mid_active", active_a, 0);
    check("rst_mid_wr_cnt", wr_cnt_a, 0);
    tb_lfsr[0] = SEED; tb_lfsr[1] = SEED;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      check("rst_mid_no_done", done_a, 0);
      check("rst_mid_no_cmd", cmd_rdy_a, 0);
    end
    run_case(1'b0, 1, 0, 64'h300, 64'h10, 0, 0);
    check("restart_first_addr", obs_first, 64'h300);

    // Randomised runs against the model, including random back-pressure.
    for (int i = 0; i < 20; i++) begin
      run_case(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               {24'h0, 40'({$urandom, $urandom})}, {24'h0, 40'({$urandom, $urandom})},
               int'($urandom_range(0, 2)), int'($urandom_range(0, 10)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
